// File: rtl/cpu_pkg.sv
// Shared encodings for the memory arbiter.
// State, grant and timer-width helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

  function automatic int cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle for mem_arbiter.
// slave: arbiter view, master: environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              needWait;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_done,
    output d_rdata, d_done,
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    output needWait, bus_err
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_done,
    input  d_rdata, d_done,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    input  needWait, bus_err
  );

endinterface

// File: rtl/wait_timer.sv
// Saturating wait-state counter for one access.
// expired flags the TIMEOUT-th cycle without ready.
module wait_timer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero TIMEOUT disables expiry entirely
  assign expired = (TIMEOUT > 0) && en && !clr
                   && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: fetch and data ports onto
// one memory port, with wait-state timeout.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  gnt_e              last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic in_acc;
  logic if_elig;
  logic d_elig;
  logic tmo;
  logic fin;

  assign in_acc = (state_q != IDLE);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_acc),
    .en      (in_acc && !bus.mem_ready),
    .expired (tmo)
  );

  // A requester still seeing its done pulse is not re-granted
  assign if_elig = bus.if_req && !if_done_q;
  assign d_elig  = bus.d_req && !d_done_q;
  assign fin     = bus.mem_ready || tmo;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_elig && (!d_elig || last_q == GNT_D)) begin
          state_d     = IF_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
        end else if (d_elig) begin
          state_d     = D_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end
      end
      IF_ACC: begin
        if (fin) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          last_d    = GNT_IF;
          if_done_d = 1'b1;
          bus_err_d = !bus.mem_ready;
          if (bus.mem_ready) begin
            if_rdata_d = bus.mem_rdata;
          end
        end
      end
      D_ACC: begin
        if (fin) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          last_d    = GNT_D;
          d_done_d  = 1'b1;
          bus_err_d = !bus.mem_ready;
          if (bus.mem_ready && !mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= GNT_D;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.bus_err   = bus_err_q;

  assign bus.needWait = (bus.if_req & ~if_done_q)
                      | (bus.d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Transaction-level bench for mem_arbiter.
// Directed cases, then randomized rounds.
module tb_mem_arbiter;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_if_rdata;
  logic [15:0] m_d_rdata;
  bit          m_last_d;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, {31'd0, bus.mem_req}, 0);
    chk({tag, "_we"}, {31'd0, bus.mem_we}, 0);
    chk({tag, "_addr"}, {16'd0, bus.mem_addr}, 0);
    chk({tag, "_wdata"}, {16'd0, bus.mem_wdata}, 0);
    chk({tag, "_dones"},
        {29'd0, bus.if_done, bus.d_done, bus.bus_err}, 0);
    chk({tag, "_ifrd"}, {16'd0, bus.if_rdata}, 0);
    chk({tag, "_drd"}, {16'd0, bus.d_rdata}, 0);
  endtask

  // One batch of requests; model: order by round-robin,
  // ready after w wait states, timeout when w+1 > TMO.
  task automatic run_round(input bit ri, input bit rd,
                           input logic [15:0] ia,
                           input logic [15:0] da,
                           input bit dwe,
                           input logic [15:0] dwd,
                           input int wi, input int wd,
                           input logic [15:0] rvi,
                           input logic [15:0] rvd,
                           input bit drop);
    int order[$];
    bus.if_req    = ri;
    bus.if_addr   = ia;
    bus.d_req     = rd;
    bus.d_addr    = da;
    bus.d_we      = dwe;
    bus.d_wdata   = dwd;
    bus.mem_ready = 1'b0;
    if (ri && rd) begin
      if (m_last_d) order = '{0, 1};
      else          order = '{1, 0};
    end else if (ri) begin
      order = '{0};
    end else if (rd) begin
      order = '{1};
    end
    foreach (order[k]) begin
      int          g;
      int          w;
      int          n;
      bit          to;
      bit          ewe;
      logic [15:0] ea;
      logic [15:0] rv;
      logic        exp_nw;
      g   = order[k];
      w   = g ? wd : wi;
      to  = (TMO > 0) && (w + 1 > TMO);
      n   = to ? TMO : w + 1;
      ea  = g ? da : ia;
      ewe = g ? dwe : 1'b0;
      rv  = g ? rvd : rvi;
      for (int c = 1; c <= n; c++) begin
        @(negedge clk);
        chk("acc_req", {31'd0, bus.mem_req}, 1);
        chk("acc_addr", {16'd0, bus.mem_addr}, {16'd0, ea});
        chk("acc_we", {31'd0, bus.mem_we}, {31'd0, ewe});
        if (ewe) chk("acc_wdata", {16'd0, bus.mem_wdata}, {16'd0, dwd});
        chk("acc_err", {31'd0, bus.bus_err}, 0);
        if (c == w + 1) begin
          bus.mem_rdata = rv;
          bus.mem_ready = 1'b1;
        end else begin
          bus.mem_rdata = 16'($urandom);
        end
        if (drop && c == 1) begin
          if (g == 1) bus.d_req = 1'b0;
          else        bus.if_req = 1'b0;
        end
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("if_done", {31'd0, bus.if_done}, {31'd0, g == 0});
      chk("d_done", {31'd0, bus.d_done}, {31'd0, g == 1});
      chk("bus_err", {31'd0, bus.bus_err}, {31'd0, to});
      chk("done_req", {31'd0, bus.mem_req}, 0);
      if (!to) begin
        if (g == 0) m_if_rdata = rv;
        else if (!dwe) m_d_rdata = rv;
      end
      chk("if_rdata", {16'd0, bus.if_rdata}, {16'd0, m_if_rdata});
      chk("d_rdata", {16'd0, bus.d_rdata}, {16'd0, m_d_rdata});
      exp_nw = (bus.if_req && g != 0) || (bus.d_req && g != 1);
      chk("needWait", {31'd0, bus.needWait}, {31'd0, exp_nw});
      m_last_d = (g == 1);
      if (g == 1) bus.d_req = 1'b0;
      else        bus.if_req = 1'b0;
    end
    @(negedge clk);
    chk("idle_req", {31'd0, bus.mem_req}, 0);
    chk("idle_done", {30'd0, bus.if_done, bus.d_done}, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    m_if_rdata    = '0;
    m_d_rdata     = '0;
    m_last_d      = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    chk("rst_nw", {31'd0, bus.needWait}, 0);
    rst = 1'b0;
    @(negedge clk);

    // single fetch, zero wait states
    run_round(1, 0, 16'h0040, 16'h0, 0, 16'h0,
              0, 0, 16'hBEEF, 16'h0, 0);
    // ties: fetch first, and again after data served last
    run_round(1, 1, 16'h0010, 16'h0020, 0, 16'h0,
              0, 0, 16'h1111, 16'h2222, 0);
    run_round(1, 1, 16'h0030, 16'h0050, 0, 16'h0,
              1, 2, 16'h3333, 16'h4444, 0);
    // store with three wait states
    run_round(0, 1, 16'h0, 16'h0100, 1, 16'h1234,
              0, 3, 16'h0, 16'hDEAD, 0);
    // timeout, then ready on the last allowed cycle
    run_round(0, 1, 16'h0, 16'h0200, 0, 16'h0,
              0, 30, 16'h0, 16'h5555, 0);
    run_round(0, 1, 16'h0, 16'h0204, 0, 16'h0,
              0, TMO - 1, 16'h0, 16'h6666, 0);
    run_round(1, 0, 16'h0300, 16'h0, 0, 16'h0,
              TMO, 0, 16'h7777, 16'h0, 0);
    // request dropped mid-access still completes
    run_round(1, 1, 16'h0400, 16'h0404, 0, 16'h0,
              2, 1, 16'h8888, 16'h9999, 1);

    // ready while idle has no effect
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("ign_req", {31'd0, bus.mem_req}, 0);
    chk("ign_done", {29'd0, bus.if_done, bus.d_done, bus.bus_err}, 0);
    @(negedge clk);
    chk("ign_ifrd", {16'd0, bus.if_rdata}, {16'd0, m_if_rdata});

    // reset during the second fetch access cycle
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0500;
    @(negedge clk);
    chk("rma_req", {31'd0, bus.mem_req}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("rma");
    rst        = 1'b0;
    bus.if_req = 1'b0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    m_last_d   = 1'b1;
    @(negedge clk);
    run_round(1, 0, 16'h0600, 16'h0, 0, 16'h0,
              1, 0, 16'hCAFE, 16'h0, 0);

    for (int r = 0; r < 60; r++) begin
      bit ri;
      bit rd;
      int wi;
      int wd;
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) ri = 1'b1;
      wi = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4)
                                     : $urandom_range(12, 18);
      wd = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4)
                                     : $urandom_range(12, 18);
      run_round(ri, rd, 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 16'($urandom),
                wi, wd, 16'($urandom), 16'($urandom),
                $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 16: data width.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles to wait for mem_ready (0 = timeout disabled).
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req / if_addr  in  1 / ADDR_W  instruction-fetch read request and its address.
REQ-007 if_rdata / if_done  out  DATA_W / 1  fetched word; one-cycle completion pulse.
REQ-008 d_req / d_we / d_addr / d_wdata  in  1 / 1 / ADDR_W / DATA_W  data request, write enable, address, write data.
REQ-009 d_rdata / d_done  out  DATA_W / 1  load result; one-cycle completion pulse.
REQ-010 mem_req / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  shared memory port.
REQ-011 mem_rdata / mem_ready  in  DATA_W / 1  memory read data; access-complete strobe.
REQ-012 needWait  out  1  stall to the control unit.
REQ-013 bus_err  out  1  one-cycle pulse on timeout.

Function
REQ-014 The arbiter SHALL use states IDLE, IF_ACC and D_ACC.
REQ-015 In IDLE, when exactly one of if_req/d_req is high, the arbiter SHALL enter that requester's ACC state on the next edge.
REQ-016 In IDLE, when both requests are high, the grant SHALL go to the requester not served by the last completed grant (round-robin).
REQ-017 The last-grant flag SHALL update only on completion or timeout.
REQ-018 At the IDLE->ACC edge, mem_addr, mem_we and mem_wdata SHALL be registered from the granted requester; mem_we SHALL be 0 for fetch.
REQ-019 These outputs SHALL be held stable for the whole ACC state.
REQ-020 mem_req SHALL be high exactly while in IF_ACC or D_ACC.
REQ-021 When mem_ready is sampled high in an ACC state, the arbiter SHALL pulse the granted requester's done for the next cycle.
REQ-022 On that same completion, mem_rdata SHALL be latched into that requester's rdata (reads only; d_rdata SHALL be unchanged on writes), and the state SHALL return to IDLE.
REQ-023 Minimum latency SHALL be 2 cycles: req high in cycle 0, mem_req in cycle 1, mem_ready in cycle 1, done in cycle 2.
REQ-024 After every completion, at least one IDLE cycle SHALL separate consecutive accesses.
REQ-025 Requesters hold req and their inputs until done; a req dropped mid-access SHALL NOT abort the access, and done SHALL still pulse.
REQ-026 mem_ready sampled while in IDLE SHALL be ignored.
REQ-027 needWait SHALL be combinational: (if_req & ~if_done) | (d_req & ~d_done).
REQ-028 With TIMEOUT>0, a wait counter SHALL clear on ACC entry and increment each ACC cycle without mem_ready.
REQ-029 On the TIMEOUT-th such cycle, the arbiter SHALL pulse bus_err and the requester's done together, leave rdata unchanged, and return to IDLE.
REQ-030 A mem_ready arriving in the same cycle the timeout fires SHALL win: normal completion, no bus_err.
REQ-031 The wait counter SHALL saturate and SHALL never wrap.

Reset
REQ-032 While rst is high, state SHALL be IDLE; mem_req, mem_we, if_done, d_done and bus_err SHALL be 0; mem_addr, mem_wdata, if_rdata, d_rdata and the wait counter SHALL be 0; the last-grant flag SHALL be "data", so the first tie goes to fetch.
REQ-033 Reset asserted mid-access SHALL abandon the access: mem_req low on the following cycle, no done pulse, no bus_err.

Structure
REQ-034 The state encoding and grant encoding (GNT_IF, GNT_D) SHALL live in the shared package cpu_pkg.
REQ-035 The wait counter plus timeout compare SHALL be one sub-module, wait_timer (ports: clk, rst, clr, en, expired), parameterised by TIMEOUT.

Verification
REQ-036 Single fetch: if_req=1, if_addr=0x0040, mem_ready in the first mem_req cycle, mem_rdata=0xBEEF -> mem_addr=0x0040, mem_we=0, if_done one cycle 2 cycles after req, if_rdata=0xBEEF, needWait low once done asserts.
REQ-037 Tie after reset: if_req and d_req high in the same cycle -> fetch granted first, then d_req after one IDLE cycle; next simultaneous pair -> fetch granted (last grant was data, so round-robin picks fetch).
REQ-038 Store with 3 wait states: d_we=1, d_addr=0x0100, d_wdata=0x1234, mem_ready on the 4th mem_req cycle -> mem_we/addr/wdata stable for 4 cycles, d_done pulse, d_rdata unchanged.
REQ-039 Timeout: TIMEOUT=15, mem_ready never asserted -> on the 15th ACC cycle bus_err and d_done pulse together, mem_req low the next cycle; with mem_ready on the 15th cycle, normal completion and no bus_err.
REQ-040 Reset mid-access: rst high during the 2nd IF_ACC cycle -> mem_req=0 next cycle, no if_done, all outputs zero; a subsequent if_req is served normally.
